// File: rtl/daten_speicher_antwort.sv
// daten_speicher_antwort
//   Responder end of the CPU data-memory handshake. It holds a word-addressed
//   data array and inserts WARTEZYKLEN wait states before every access. It
//   signals completion with a one-cycle pulse. The word address IO_ADRESSE is
//   mapped onto the IORegister output instead of the array.
// Ports
//   Clock            rising-edge clock
//   Reset            synchronous, active-low reset
//   LesenAn          read request, held until DatenBereit
//   SchreibenAn      write request, held until DatenGeschrieben
//   Adresse          word address, latched in IDLE
//   DatenRein        write data, latched in IDLE
//   DatenRaus        read data, held until the next read completes
//   DatenBereit      one-cycle read-completion pulse
//   DatenGeschrieben one-cycle write-completion pulse
//   Beschaeftigt     high while waiting or recovering
//   Fehler           pulses with completion for an out-of-range address
//   IORegister       memory-mapped output register
module daten_speicher_antwort #(
  parameter int          WORDSIZE    = 32,
  parameter int          WORDS       = 256,
  parameter int          WARTEZYKLEN = 2,
  parameter logic [31:0] IO_ADRESSE  = 32'hFFFF_FFF0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                LesenAn,
  input  logic                SchreibenAn,
  input  logic [31:0]         Adresse,
  input  logic [WORDSIZE-1:0] DatenRein,
  output logic [WORDSIZE-1:0] DatenRaus,
  output logic                DatenBereit,
  output logic                DatenGeschrieben,
  output logic                Beschaeftigt,
  output logic                Fehler,
  output logic [WORDSIZE-1:0] IORegister
);

  localparam int AW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WARTEN, ANTWORT, ERHOLUNG} zustand_t;

  zustand_t            zustand;
  logic [3:0]          zaehler;
  logic [31:0]         adr_l;
  logic [WORDSIZE-1:0] daten_l;
  logic                op_schreiben;

  logic [WORDSIZE-1:0] mem [WORDS];

  logic          ist_io;
  logic          im_bereich;
  logic [AW-1:0] idx;
  logic          anfrage_aktiv;

  always_comb begin
    ist_io        = (adr_l == IO_ADRESSE);
    im_bereich    = (adr_l < 32'(WORDS));
    idx           = adr_l[AW-1:0];
    // Only the request belonging to the latched operation keeps the access alive.
    anfrage_aktiv = op_schreiben ? SchreibenAn : LesenAn;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      zustand          <= IDLE;
      zaehler          <= '0;
      adr_l            <= '0;
      daten_l          <= '0;
      op_schreiben     <= 1'b0;
      DatenRaus        <= '0;
      DatenBereit      <= 1'b0;
      DatenGeschrieben <= 1'b0;
      Beschaeftigt     <= 1'b0;
      Fehler           <= 1'b0;
      IORegister       <= '0;
    end else begin
      DatenBereit      <= 1'b0;
      DatenGeschrieben <= 1'b0;
      Fehler           <= 1'b0;
      Beschaeftigt     <= 1'b0;
      unique case (zustand)
        IDLE: begin
          if (LesenAn || SchreibenAn) begin
            adr_l        <= Adresse;
            daten_l      <= DatenRein;
            op_schreiben <= SchreibenAn;  // write wins over a simultaneous read
            zaehler      <= 4'(WARTEZYKLEN);
            if (WARTEZYKLEN == 0) begin
              zustand <= ANTWORT;
            end else begin
              zustand      <= WARTEN;
              Beschaeftigt <= 1'b1;
            end
          end
        end
        WARTEN: begin
          if (!anfrage_aktiv) begin
            zustand <= IDLE;
          end else if (zaehler == 4'd1) begin
            zustand <= ANTWORT;
          end else begin
            zaehler      <= zaehler - 4'd1;
            Beschaeftigt <= 1'b1;
          end
        end
        ANTWORT: begin
          zustand      <= ERHOLUNG;
          Beschaeftigt <= 1'b1;
          Fehler       <= !ist_io && !im_bereich;
          if (op_schreiben) begin
            DatenGeschrieben <= 1'b1;
            if (ist_io) IORegister <= daten_l;
          end else begin
            DatenBereit <= 1'b1;
            if (ist_io)          DatenRaus <= IORegister;
            else if (im_bereich) DatenRaus <= mem[idx];
            else                 DatenRaus <= '0;
          end
        end
        ERHOLUNG: begin
          zustand <= IDLE;
        end
        default: zustand <= IDLE;
      endcase
    end
  end

  // Array kept out of the reset block so contents survive reset; the Reset
  // qualifier makes a reset in the ANTWORT cycle abort the write.
  always_ff @(posedge Clock) begin
    if (Reset && zustand == ANTWORT && op_schreiben && !ist_io && im_bereich)
      mem[idx] <= daten_l;
  end

endmodule
